// File: rtl/updown_display_counter.sv
// Prescaled up/down counter with wrap pulse and a 7-segment display decoder
// that shows the count in hexadecimal or decimal.
module updown_display_counter #(
   parameter int N       = 6,
   parameter int MAX_VAL = 2**N - 1,
   parameter int RST_VAL = MAX_VAL,
   parameter int DIV     = 1,
   parameter int DIGITS  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [N-1:0]          load_val,
   input  logic                  bcd_mode,
   output logic [N-1:0]          count,
   output logic                  tc,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [N-1:0]    MAX_C    = N'(MAX_VAL);
   localparam logic [N-1:0]    RST_C    = N'(RST_VAL);
   localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
   localparam logic [31:0]     DEC_MAX  = 32'(10**DIGITS - 1);

   logic [PW-1:0] presc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= RST_C;
         presc <= '0;
         tc    <= 1'b0;
      end else if (load) begin
         // Out-of-range load values clamp so the count never leaves 0..MAX_VAL.
         count <= (load_val > MAX_C) ? MAX_C : load_val;
         presc <= '0;
         tc    <= 1'b0;
      end else if (en) begin
         if (presc == PRE_LAST) begin
            presc <= '0;
            if (up) begin
               if (count == MAX_C) begin
                  count <= '0;
                  tc    <= 1'b1;
               end else begin
                  count <= count + 1'b1;
                  tc    <= 1'b0;
               end
            end else begin
               if (count == '0) begin
                  count <= MAX_C;
                  tc    <= 1'b1;
               end else begin
                  count <= count - 1'b1;
                  tc    <= 1'b0;
               end
            end
         end else begin
            presc <= presc + 1'b1;
            tc    <= 1'b0;
         end
      end else begin
         tc <= 1'b0;
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   logic [31:0] cnt32;
   logic        dec_ovf;

   assign cnt32   = 32'(count);
   assign dec_ovf = (cnt32 > DEC_MAX);

   // Zero-extension of count makes nibbles and decimal digits above N read as 0.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      localparam logic [31:0] P10 = 32'(10**k);
      logic [3:0] hex_nib;
      logic [3:0] dec_dig;

      assign hex_nib = 4'(cnt32 >> (4*k));
      assign dec_dig = 4'((cnt32 / P10) % 32'd10);
      assign seg[7*k +: 7] = !bcd_mode ? glyph(hex_nib) :
                             dec_ovf   ? 7'b0111111    : glyph(dec_dig);
   end

endmodule

// File: tb/tb_updown_display_counter.sv
// Directed bench for updown_display_counter: three configurations share one
// clock/reset; expected outputs go into a queue drained by a negedge monitor.
module tb_updown_display_counter;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GF = 7'b0001110;
   localparam logic [6:0] GD = 7'b0111111;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       en_a, up_a, load_a, bcd_a, tc_a;
   logic [5:0] lv_a, count_a;
   logic [13:0] seg_a;
   logic       en_b, up_b, load_b, bcd_b, tc_b;
   logic [7:0] lv_b, count_b;
   logic [13:0] seg_b;
   logic       en_c, up_c, load_c, bcd_c, tc_c;
   logic [7:0] lv_c, count_c;
   logic [13:0] seg_c;

   // entry: {id[1:0], chk_seg, tc, count[7:0], seg[13:0]}
   logic [25:0] exp_q[$];
   int checks = 0;
   int passes = 0;
   int n_entry = 0;

   always #5 clk = ~clk;

   updown_display_counter u_a (
      .clk(clk), .reset(reset), .en(en_a), .up(up_a), .load(load_a),
      .load_val(lv_a), .bcd_mode(bcd_a), .count(count_a), .tc(tc_a), .seg(seg_a)
   );

   updown_display_counter #(.N(8), .MAX_VAL(99), .DIV(1), .DIGITS(2)) u_b (
      .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b),
      .load_val(lv_b), .bcd_mode(bcd_b), .count(count_b), .tc(tc_b), .seg(seg_b)
   );

   updown_display_counter #(.N(8), .MAX_VAL(150), .RST_VAL(0), .DIV(4), .DIGITS(2)) u_c (
      .clk(clk), .reset(reset), .en(en_c), .up(up_c), .load(load_c),
      .load_val(lv_c), .bcd_mode(bcd_c), .count(count_c), .tc(tc_c), .seg(seg_c)
   );

   task automatic expect_out(input logic [1:0] id, input logic chk_seg, input logic t,
                             input logic [7:0] c, input logic [13:0] s);
      exp_q.push_back({id, chk_seg, t, c, s});
   endtask

   task automatic step_chk(input logic [1:0] id, input logic chk_seg, input logic t,
                           input logic [7:0] c, input logic [13:0] s);
      @(posedge clk);
      #1;
      expect_out(id, chk_seg, t, c, s);
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [13:0] got,
                      input logic [13:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s #%0d: got %b, expected %b", nm, idx, got, want);
   endtask

   // Monitor: compares every queued expectation at the falling edge.
   logic [25:0] mon_e;
   logic [7:0]  act_c;
   logic        act_t;
   logic [13:0] act_s;
   string       dn;
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_entry++;
            case (mon_e[25:24])
               2'd0: begin act_c = {2'b00, count_a}; act_t = tc_a; act_s = seg_a; dn = "a"; end
               2'd1: begin act_c = count_b; act_t = tc_b; act_s = seg_b; dn = "b"; end
               default: begin act_c = count_c; act_t = tc_c; act_s = seg_c; dn = "c"; end
            endcase
            chk({"count_", dn}, n_entry, 14'(act_c), 14'(mon_e[21:14]));
            chk({"tc_", dn}, n_entry, 14'(act_t), 14'(mon_e[22]));
            if (mon_e[23]) chk({"seg_", dn}, n_entry, act_s, mon_e[13:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end before 100000 ns");
      $fatal(1, "timeout");
   end

   initial begin
      int m;
      int prev;
      int seq1[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
      int seq2[4] = '{0, 0, 0, 1};
      en_a = 0; up_a = 0; load_a = 0; bcd_a = 0; lv_a = '0;
      en_b = 0; up_b = 0; load_b = 0; bcd_b = 1; lv_b = '0;
      en_c = 0; up_c = 0; load_c = 0; bcd_c = 0; lv_c = '0;

      // Reset values
      expect_out(2'd0, 1'b1, 1'b0, 8'd63, {G3, GF});
      expect_out(2'd1, 1'b1, 1'b0, 8'd99, {G9, G9});
      expect_out(2'd2, 1'b1, 1'b0, 8'd0, {G0, G0});
      @(negedge clk);
      #1;
      reset = 0;

      // Defaults counting down through the wrap
      en_a = 1; up_a = 0;
      m = 63;
      for (int i = 1; i <= 64; i++) begin
         prev = m;
         m = (m == 0) ? 63 : m - 1;
         step_chk(2'd0, (i == 64), (prev == 0), 8'(m), {G3, GF});
      end
      en_a = 0; bcd_a = 1;
      step_chk(2'd0, 1'b1, 1'b0, 8'd63, {G6, G3});
      load_a = 1; lv_a = 6'd10;
      step_chk(2'd0, 1'b1, 1'b0, 8'd10, {G1, G0});
      load_a = 0; en_a = 1; up_a = 1;
      step_chk(2'd0, 1'b1, 1'b0, 8'd11, {G1, G1});

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2;
      reset = 1;
      expect_out(2'd0, 1'b1, 1'b0, 8'd63, {G6, G3});
      expect_out(2'd1, 1'b1, 1'b0, 8'd99, {G9, G9});
      expect_out(2'd2, 1'b1, 1'b0, 8'd0, {G0, G0});
      @(negedge clk);
      #1;
      reset = 0; en_a = 0;

      // MAX_VAL=99 decimal wrap and load clamp
      load_b = 1; lv_b = 8'd98;
      step_chk(2'd1, 1'b1, 1'b0, 8'd98, {G9, G8});
      load_b = 0; en_b = 1; up_b = 1;
      step_chk(2'd1, 1'b1, 1'b0, 8'd99, {G9, G9});
      step_chk(2'd1, 1'b1, 1'b1, 8'd0, {G0, G0});
      step_chk(2'd1, 1'b1, 1'b0, 8'd1, {G0, G1});
      en_b = 0;
      step_chk(2'd1, 1'b0, 1'b0, 8'd1, 14'd0);
      load_b = 1; lv_b = 8'd200;
      step_chk(2'd1, 1'b1, 1'b0, 8'd99, {G9, G9});
      lv_b = 8'd0;
      step_chk(2'd1, 1'b1, 1'b0, 8'd0, {G0, G0});
      load_b = 0; en_b = 1; up_b = 0;
      step_chk(2'd1, 1'b1, 1'b1, 8'd99, {G9, G9});
      en_b = 0;

      // DIV=4 prescaler, enable gap and direction change
      en_c = 1; up_c = 1;
      for (int i = 0; i < 8; i++) step_chk(2'd2, 1'b0, 1'b0, 8'(seq1[i]), 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd2, 14'd0);
      en_c = 0; up_c = 0;
      for (int i = 0; i < 3; i++) step_chk(2'd2, 1'b0, 1'b0, 8'd2, 14'd0);
      en_c = 1;
      step_chk(2'd2, 1'b0, 1'b0, 8'd2, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd2, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd1, 14'd0);

      // Load clamp to 150, hex and decimal-overflow display
      load_c = 1; lv_c = 8'd200;
      step_chk(2'd2, 1'b1, 1'b0, 8'd150, {G9, G6});
      load_c = 0; en_c = 0; bcd_c = 1;
      step_chk(2'd2, 1'b1, 1'b0, 8'd150, {GD, GD});

      // Load in the step cycle beats the wrap
      bcd_c = 0; en_c = 1; up_c = 1;
      for (int i = 0; i < 3; i++) step_chk(2'd2, 1'b0, 1'b0, 8'd150, 14'd0);
      load_c = 1; lv_c = 8'd5;
      step_chk(2'd2, 1'b1, 1'b0, 8'd5, {G0, G5});
      load_c = 0;
      step_chk(2'd2, 1'b0, 1'b0, 8'd5, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd5, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd5, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd6, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd6, 14'd0);
      step_chk(2'd2, 1'b0, 1'b0, 8'd6, 14'd0);

      // Reset mid-prescale restarts the prescaler
      @(posedge clk);
      #2;
      reset = 1;
      expect_out(2'd2, 1'b1, 1'b0, 8'd0, {G0, G0});
      @(negedge clk);
      #1;
      reset = 0;
      for (int i = 0; i < 4; i++) step_chk(2'd2, 1'b0, 1'b0, 8'(seq2[i]), 14'd0);
      en_c = 0;

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/updown_display_counter.md
UPDOWN_DISPLAY_COUNTER -- requirements
Module: updown_display_counter

Interface
REQ-001 SHALL have parameter N, default 6, meaning counter width in bits (2..16).
REQ-002 SHALL have parameter MAX_VAL, default 2**N-1, meaning counter upper bound (1..2**N-1).
REQ-003 SHALL have parameter RST_VAL, default MAX_VAL, meaning count value loaded by reset.
REQ-004 SHALL have parameter DIV, default 1, meaning enabled clock cycles per count step (>=1).
REQ-005 SHALL have parameter DIGITS, default 2, meaning number of 7-segment digits driven (1..5).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 en  input  1  count enable; prescaler and counter hold when low.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  N  value taken on load.
REQ-012 bcd_mode  input  1  display format: 1 = decimal, 0 = hexadecimal.
REQ-013 count  output  N  current counter value, registered.
REQ-014 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-015 seg  output  7*DIGITS  segment bus; digit k at seg[7k+6:7k], digit 0 least significant; per digit bit order {g,f,e,d,c,b,a}, active-low.

Function
REQ-016 Prescaler SHALL count 0..DIV-1 on each cycle with en=1; a step occurs in the cycle the prescaler equals DIV-1, prescaler then returns to 0; DIV=1 SHALL step every enabled cycle.
REQ-017 en=0 SHALL freeze prescaler, count and hold tc low.
REQ-018 Step with up=1 SHALL set count to count+1, or 0 when count = MAX_VAL.
REQ-019 Step with up=0 SHALL set count to count-1, or MAX_VAL when count = 0.
REQ-020 A wrapping step (MAX_VAL->0 up, 0->MAX_VAL down) SHALL drive tc high in exactly the following cycle, coincident with the wrapped count value; tc low otherwise.
REQ-021 load=1 SHALL take priority over en and step: count <= min(load_val, MAX_VAL), prescaler <= 0, tc <= 0, next cycle.
REQ-022 Direction change (up toggled) SHALL take effect on the next step, without resetting the prescaler.
REQ-023 count values outside 0..MAX_VAL SHALL be unreachable.
REQ-024 seg SHALL be combinational from count and bcd_mode (zero latency relative to count).
REQ-025 Hex mode: digit k SHALL show nibble count[4k+3:4k] as 0-9,A,b,C,d,E,F; nibbles beyond N SHALL show 0.
REQ-026 Decimal mode: digit k SHALL show decimal digit k of count; leading digits show 0.
REQ-027 Decimal mode with count > 10**DIGITS-1 SHALL show '-' (7'b0111111) on all digits.
REQ-028 Glyph codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-029 reset=1 SHALL asynchronously set count=RST_VAL, prescaler=0, tc=0; seg follows count.
REQ-030 reset asserted mid-prescale or coincident with load SHALL win; first step after release occurs DIV enabled cycles later.

Verification
REQ-031 Defaults, reset release, en=1, up=0 -> count 63,62,...,0,63; tc=1 only in cycle count returns to 63; seg shows "3F" at 63.
REQ-032 N=8, MAX_VAL=99, up=1, bcd_mode=1 -> 98,99,0; tc pulse at 0; seg shows "99" then "00".
REQ-033 DIV=4, en=1 -> count steps once per 4 cycles; drop en for 3 cycles mid-prescale -> step delayed by exactly 3 cycles.
REQ-034 load=1, load_val=200 with MAX_VAL=150 -> count=150 next cycle; load with en=1 in step cycle -> load value wins, tc=0.
REQ-035 Defaults, bcd_mode=1, count=63 -> "63"; N=8, count=200, DIGITS=2 -> "--".
REQ-036 Assert reset asynchronously mid-count (between clock edges) -> count=RST_VAL immediately, tc=0, prescaler restarted.
